cla_seq_subtractor: RTL

Multi-cycle wide subtractor, the inverse-direction companion to the team's registered 4-bit carry-look-ahead adder. It computes A − B − bin over a WIDTH-bit operand by walking one 4-bit CLA slice per clock, least-significant slice first, and chaining the carry between slices. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source and a result sink in the datapath.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla4_slice.sv | 30 +++
 rtl/cla_seq_subtractor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential CLA subtractor: slice width, FSM states
// and the slice-count helper.
package cla_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   function automatic int unsigned num_slices(input int unsigned width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder slice with group generate/propagate.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       gout,
   output logic       pout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pout = &p;
   assign cout = gout | (pout & cin);

   assign s = p ^ c;

endmodule

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle A - B - bin, one 4-bit CLA slice per clock, LSB slice first.
// Define CLA_SUB_OVF_EN to add the registered signed-overflow output ovf.
module cla_seq_subtractor
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
`ifdef CLA_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned N  = num_slices(WIDTH);
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KLAST = KW'(N - 1);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("WIDTH must be a non-zero multiple of 4");
   end

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] nb_q;
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             zero_q;
   logic             out_valid_q;

   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_cout;
   logic               slice_gout;
   logic               slice_pout;
   logic [WIDTH-1:0]   diff_next;

   always_comb begin
      slice_a   = a_q[k_q*SLICE_W +: SLICE_W];
      slice_b   = nb_q[k_q*SLICE_W +: SLICE_W];
      diff_next = diff_q;
      diff_next[k_q*SLICE_W +: SLICE_W] = slice_s;
   end

   cla4_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout),
      .gout (slice_gout),
      .pout (slice_pout)
   );

   // Group terms are only needed when slices are chained in parallel.
   logic unused_gp;
   assign unused_gp = slice_gout ^ slice_pout;

`ifdef CLA_SUB_OVF_EN
   logic ovf_q;
   // nb_q holds ~b, so the original subtrahend sign is ~nb_q[MSB].
   logic ovf_next;
   assign ovf_next = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         nb_q        <= '0;
         carry_q     <= 1'b0;
         k_q         <= '0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef CLA_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= a;
                  nb_q    <= ~b;
                  carry_q <= ~bin;
                  k_q     <= '0;
                  diff_q  <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               diff_q  <= diff_next;
               carry_q <= slice_cout;
               if (k_q == KLAST) begin
                  bout_q      <= ~slice_cout;
                  zero_q      <= (diff_next == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
`ifdef CLA_SUB_OVF_EN
                  ovf_q       <= ovf_next;
`endif
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign zero      = zero_q;
`ifdef CLA_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
